// File: rtl/fp_mini_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fp_mini_pkg
// Purpose  : Shared widths, constants and types for the 7-bit mini-float
//            add/sub datapath, format {exp[2:0], mant[3:0]}.
// Revision : 1.0 - initial release
// ============================================================================
package fp_mini_pkg;

    localparam int EXP_W = 3;
    localparam int MAN_W = 4;

    localparam logic [EXP_W-1:0] EXP_MAX  = 3'd7;
    localparam logic [MAN_W-1:0] MANT_SAT = 4'hF;

    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
    } fp7_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } norm_state_t;

endpackage : fp_mini_pkg
`default_nettype wire

// File: rtl/fp_addsub_normalize_if.sv
`default_nettype none
// ============================================================================
// Interface : fp_addsub_normalize_if
// Purpose   : Raw-sum input and normalized-result output handshakes of the
//             post-add normalizer.
// Revision  : 1.0 - initial release
// ============================================================================
interface fp_addsub_normalize_if #(
    parameter int EXP_W = fp_mini_pkg::EXP_W,
    parameter int MAN_W = fp_mini_pkg::MAN_W
);

    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sign;
    logic [EXP_W-1:0]       in_exp;
    logic [MAN_W:0]         in_mant;

    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W-1:0] out_result;
    logic                   out_sign;
    logic                   out_overflow;
    logic                   out_zero;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_result, out_sign, out_overflow, out_zero
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_result, out_sign, out_overflow, out_zero
    );

endinterface : fp_addsub_normalize_if
`default_nettype wire

// File: rtl/fp_lzc4.sv
`default_nettype none
// ============================================================================
// Module   : fp_lzc4
// Purpose  : Combinational 4-bit leading-zero counter (0..4). Present only in
//            builds with FPNORM_LZC_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef FPNORM_LZC_EN
module fp_lzc4 (
    input  wire logic [3:0] i_data,
    output logic      [2:0] o_count
);

    always_comb begin
        o_count = 3'd4;
        casez (i_data)
            4'b1???: o_count = 3'd0;
            4'b01??: o_count = 3'd1;
            4'b001?: o_count = 3'd2;
            4'b0001: o_count = 3'd3;
            default: o_count = 3'd4;
        endcase
    end

endmodule : fp_lzc4
`endif
`default_nettype wire

// File: rtl/fp_addsub_normalize.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_normalize
// Purpose  : Post-add normalizer: carry right-shift, saturation, zero detect
//            and left-normalization. FPNORM_LZC_EN selects single-cycle LZC.
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_normalize #(
    parameter int EXP_W = fp_mini_pkg::EXP_W,
    parameter int MAN_W = fp_mini_pkg::MAN_W
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    fp_addsub_normalize_if.slave bus
);

    import fp_mini_pkg::*;

    norm_state_t      state_q, state_d;
    logic             sign_q,  sign_d;
    logic [EXP_W-1:0] exp_q,   exp_d;
    logic [MAN_W:0]   mant_q,  mant_d;
    logic             ovf_q,   ovf_d;
    logic             zero_q,  zero_d;
    fp7_t             result_w;

`ifdef FPNORM_LZC_EN
    logic [2:0]       lzc_w;
    logic [EXP_W-1:0] shift_w;

    fp_lzc4 u_lzc (
        .i_data  (mant_q[MAN_W-1:0]),
        .o_count (lzc_w)
    );

    // Never shift past exponent 0: the value stays denormal instead.
    assign shift_w = (EXP_W'(lzc_w) < exp_q) ? EXP_W'(lzc_w) : exp_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.in_sign;
                    exp_d   = bus.in_exp;
                    mant_d  = bus.in_mant;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = NORM;
                end
            end

            NORM: begin
                state_d = DONE;
                if (mant_q[MAN_W] && (exp_q == EXP_MAX)) begin
                    exp_d  = EXP_MAX;
                    mant_d = {1'b0, MANT_SAT};
                    ovf_d  = 1'b1;
                end else if (mant_q[MAN_W]) begin
                    mant_d = mant_q >> 1;
                    exp_d  = exp_q + EXP_W'(1);
                end else if (mant_q == '0) begin
                    mant_d = '0;
                    exp_d  = '0;
                    zero_d = 1'b1;
                end else if (!mant_q[MAN_W-1] && (exp_q != '0)) begin
                    // Already-normalized and denormal values fall through to DONE untouched.
`ifdef FPNORM_LZC_EN
                    mant_d = mant_q << shift_w;
                    exp_d  = exp_q - shift_w;
`else
                    mant_d  = mant_q << 1;
                    exp_d   = exp_q - EXP_W'(1);
                    state_d = NORM;
`endif
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign result_w = {exp_q, mant_q[MAN_W-1:0]};

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.out_result   = result_w;
    assign bus.out_sign     = sign_q;
    assign bus.out_overflow = ovf_q;
    assign bus.out_zero     = zero_q;

endmodule : fp_addsub_normalize
`default_nettype wire

// File: tb/tb_fp_addsub_normalize.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_normalize
// Purpose  : Scoreboard bench for fp_addsub_normalize (both FPNORM_LZC_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_normalize;

    logic clk = 1'b0;
    logic rst_n;

    fp_addsub_normalize_if bus ();

    fp_addsub_normalize dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0] result;
        logic       sign;
        logic       ovf;
        logic       zero;
        int         lat;
    } exp_item_t;

    exp_item_t sb_q[$];
    int        checks     = 0;
    int        passes     = 0;
    int        stall_mode = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Value-level reference: saturate, halve on carry, or double until the
    // hidden bit is set or the exponent bottoms out.
    function automatic exp_item_t model(input logic s, input int e, input int m);
        exp_item_t r;
        int n;
        n      = 0;
        r.sign = s;
        r.ovf  = 1'b0;
        r.zero = 1'b0;
        if (m >= 16) begin
            if (e == 7) begin
                r.ovf = 1'b1;
                m     = 15;
            end else begin
                m = m / 2;
                e = e + 1;
            end
        end else if (m == 0) begin
            r.zero = 1'b1;
            e      = 0;
        end else begin
            while (m < 8 && e > 0) begin
                m = m * 2;
                e = e - 1;
                n++;
            end
        end
        r.result = 7'(e * 16 + m);
`ifdef FPNORM_LZC_EN
        r.lat = 1;
`else
        r.lat = n + 1;
`endif
        return r;
    endfunction

    task automatic send(input logic s, input logic [2:0] e, input logic [4:0] m);
        exp_item_t x;
        int w;
        w = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        while (!bus.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        x     = model(s, int'(e), int'(m));
        x.lat = cyc + 1 + x.lat;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sign  = 1'($urandom);
        bus.in_exp   = 3'($urandom);
        bus.in_mant  = 5'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb_q.size() != 0 || !bus.in_ready) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    // Monitor: pops on each new result, checks holds under backpressure.
    initial begin
        exp_item_t  e;
        logic [6:0] s_res;
        logic       s_sign, s_ovf, s_zero;
        bit         held;
        int         stall;
        held  = 1'b0;
        stall = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (!held) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("result",   bus.out_result,   e.result);
                        chk("sign",     bus.out_sign,     e.sign);
                        chk("overflow", bus.out_overflow, e.ovf);
                        chk("zero",     bus.out_zero,     e.zero);
                        chk("latency",  cyc,              e.lat);
                    end
                    s_res  = bus.out_result;
                    s_sign = bus.out_sign;
                    s_ovf  = bus.out_overflow;
                    s_zero = bus.out_zero;
                    stall  = (stall_mode != 0) ? 5 : int'($urandom_range(0, 2));
                end else begin
                    chk("hold_result",   bus.out_result,   s_res);
                    chk("hold_sign",     bus.out_sign,     s_sign);
                    chk("hold_overflow", bus.out_overflow, s_ovf);
                    chk("hold_zero",     bus.out_zero,     s_zero);
                    chk("in_ready_busy", bus.in_ready,     0);
                    stall--;
                end
                bus.out_ready = (stall <= 0);
                held = !bus.out_ready;
            end else begin
                held = 1'b0;
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b1;
        bus.in_exp   = 3'd5;
        bus.in_mant  = 5'h13;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid",    bus.out_valid,    0);
        chk("rst_out_result",   bus.out_result,   0);
        chk("rst_out_sign",     bus.out_sign,     0);
        chk("rst_out_overflow", bus.out_overflow, 0);
        chk("rst_out_zero",     bus.out_zero,     0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);

        send(1'b1, 3'd3, 5'b1_0110);
        send(1'b0, 3'd7, 5'b1_0001);
        send(1'b0, 3'd5, 5'b0_0001);
        send(1'b0, 3'd1, 5'b0_0010);
        send(1'b1, 3'd4, 5'b0_0000);
        send(1'b0, 3'd0, 5'b1_1111);
        send(1'b1, 3'd6, 5'b0_0111);

        repeat (150) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send(1'($urandom), 3'($urandom), 5'($urandom));
        end
        drain();

        stall_mode = 1;
        send(1'b1, 3'd2, 5'b0_1000);
        drain();
        stall_mode = 0;

        // Reset while the value is still being normalized.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 3'd5;
        bus.in_mant  = 5'b0_0001;
        chk("pre_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_valid", bus.out_valid, 0);
        end

        send(1'b0, 3'd6, 5'b0_0011);
        send(1'b1, 3'd2, 5'b0_0101);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_fp_addsub_normalize
`default_nettype wire
